// File: rtl/lap_stopwatch.sv
// Millisecond lap stopwatch: debounced-edge request inputs, BCD counter with
// wrap/saturate, lap freeze and a registered multiplexed 7-segment driver.
module lap_stopwatch #(
  parameter int CLK_DIV    = 49999,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 8192,
  parameter int DP_POS     = 3,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    running,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] count_bcd
);

  localparam int PW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_OVF = 2'd3} state_t;

  function automatic logic all_nines(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (v[4*d +: 4] != 4'd9) r = 1'b0;
      else r = r;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    c = 1'b1;
    r = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (c && (v[4*d +: 4] == 4'd9)) begin
        r[4*d +: 4] = 4'd0;
      end else if (c) begin
        r[4*d +: 4] = v[4*d +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        r[4*d +: 4] = v[4*d +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // bit order everywhere: 0=start 1=stop 2=clear 3=lap
  logic [3:0] sync1_q, sync2_q, prev_q, armed_q;
  logic       valid_q;
  logic       start_s, stop_s, clear_s, lap_s;

  // Input synchronizers; a request only counts once its level was seen low after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      prev_q  <= 4'b0000;
      armed_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= {lap, clear, stop, start};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      armed_q <= armed_q | ({4{valid_q}} & ~sync1_q);
      valid_q <= 1'b1;
    end
  end

  assign start_s = sync2_q[0] & ~prev_q[0] & armed_q[0];
  assign stop_s  = sync2_q[1] & ~prev_q[1] & armed_q[1];
  assign clear_s = sync2_q[2] & ~prev_q[2] & armed_q[2];
  assign lap_s   = sync2_q[3] & ~prev_q[3] & armed_q[3];

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d, disp_q, disp_d;
  logic            ovf_q, ovf_d, lap_q, lap_d, run_q, run_d, tick_s;
  logic [SW-1:0]   scan_q, scan_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic            dp_q, dp_d;

  // Next-state logic: FSM, prescaler, BCD count and lap freeze.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    lap_d   = lap_q;
    tick_s  = 1'b0;
    disp_d  = lap_q ? disp_q : count_q;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        lap_d   = 1'b0;
        if (start_s && !stop_s) state_d = S_RUN;
        else state_d = S_IDLE;
      end
      S_RUN: begin
        if (presc_q == PW'(CLK_DIV)) begin
          presc_d = '0;
          tick_s  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (lap_s) lap_d = ~lap_q;
        else lap_d = lap_q;
        if (stop_s) state_d = S_PAUSE;
        else state_d = S_RUN;
        // saturation outranks a concurrent stop request
        if (tick_s && all_nines(count_q)) begin
          ovf_d = 1'b1;
          if (WRAP != 0) count_d = '0;
          else state_d = S_OVF;
        end else if (tick_s) begin
          count_d = bcd_inc(count_q);
        end else begin
          count_d = count_q;
        end
      end
      S_PAUSE, S_OVF: begin
        if (clear_s) begin
          state_d = S_IDLE;
          presc_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          lap_d   = 1'b0;
        end else begin
          if (lap_s) lap_d = ~lap_q;
          else lap_d = lap_q;
          if ((state_q == S_PAUSE) && start_s && !stop_s) state_d = S_RUN;
          else state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d = (state_d == S_RUN);
  end

  // Free-running digit scan and registered display drive.
  always_comb begin
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) idx_d = '0;
      else idx_d = idx_q + IW'(1);
    end else begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
    end
    seg_d = seg_enc(disp_q[{idx_q, 2'b00} +: 4]);
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    if (int'(idx_q) == DP_POS) dp_d = 1'b0;
    else dp_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      count_q <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      lap_q   <= 1'b0;
      run_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      lap_q   <= lap_d;
      run_q   <= run_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign segment   = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign running   = run_q;
  assign overflow  = ovf_q;
  assign count_bcd = count_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: a wrapping and a saturating instance share stimulus
// and are compared against an integer-arithmetic reference model.
module tb_lap_stopwatch;
  localparam int CLK_DIV = 3;
  localparam int ND = 2;
  localparam int SCAN_DIV = 2;
  localparam int MAXC = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVF = 3;
  localparam logic [19:0] RV = {1'b0, 1'b0, 8'h00, 7'h7F, 2'b11, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = 4'b0000;  // 0=start 1=stop 2=clear 3=lap
  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;
  logic dp1, dp0, run1, run0, ovf1, ovf0;
  logic [7:0] cnt1, cnt0;
  logic [19:0] v1, v0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .SCAN_DIV(SCAN_DIV), .DP_POS(3), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .start(req[0]), .stop(req[1]), .clear(req[2]), .lap(req[3]),
    .segment(seg1), .an(an1), .dp(dp1), .running(run1), .overflow(ovf1), .count_bcd(cnt1));
  lap_stopwatch #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .SCAN_DIV(SCAN_DIV), .DP_POS(3), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(req[0]), .stop(req[1]), .clear(req[2]), .lap(req[3]),
    .segment(seg0), .an(an0), .dp(dp0), .running(run0), .overflow(ovf0), .count_bcd(cnt0));

  assign v1 = {run1, ovf1, cnt1, seg1, an1, dp1};
  assign v0 = {run0, ovf0, cnt0, seg0, an0, dp0};

  typedef struct packed {
    int state; int cnt; int presc; int disp; int scan; int idx;
    bit ovf; bit lap; bit [6:0] seg; bit [1:0] an; bit dp;
    bit [3:0] armed; bit [3:0] prevh; bit [3:0] p1; bit [3:0] p2;
  } model_t;
  model_t m1, m0;

  function automatic bit [6:0] enc(int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [19:0] exp_vec(model_t m);
    return {(m.state == S_RUN), m.ovf, to_bcd(m.cnt), m.seg, m.an, m.dp};
  endfunction

  // One clock of the reference: a request acts two edges after the edge that first sees it high.
  function automatic model_t step(model_t m, logic rst, logic [3:0] raw, bit wrap);
    model_t n;
    bit [3:0] ap;
    bit tick;
    n = m;
    if (rst) begin
      n = '0; n.seg = 7'h7F; n.an = 2'b11; n.dp = 1'b1;
      return n;
    end
    n.seg = enc((m.idx == 0) ? m.disp % 10 : m.disp / 10);
    n.an = (m.idx == 0) ? 2'b10 : 2'b01;
    n.dp = 1'b1;
    if (m.scan == SCAN_DIV - 1) begin n.scan = 0; n.idx = (m.idx + 1) % ND; end
    else n.scan = m.scan + 1;
    n.disp = m.lap ? m.disp : m.cnt;
    ap = m.p2;
    n.p2 = m.p1;
    for (int i = 0; i < 4; i++) begin
      n.p1[i] = raw[i] && !m.prevh[i] && m.armed[i];
      n.armed[i] = m.armed[i] || !raw[i];
      n.prevh[i] = raw[i];
    end
    case (m.state)
      S_IDLE: begin
        n.cnt = 0; n.presc = 0; n.ovf = 0; n.lap = 0;
        if (ap[0] && !ap[1]) n.state = S_RUN;
      end
      S_RUN: begin
        tick = (m.presc == CLK_DIV);
        n.presc = tick ? 0 : m.presc + 1;
        if (ap[3]) n.lap = !m.lap;
        if (ap[1]) n.state = S_PAUSE;
        if (tick && m.cnt == MAXC) begin
          n.ovf = 1;
          if (wrap) n.cnt = 0; else n.state = S_OVF;
        end else if (tick) n.cnt = m.cnt + 1;
      end
      default: begin
        if (ap[2]) begin
          n.state = S_IDLE; n.cnt = 0; n.presc = 0; n.ovf = 0; n.lap = 0;
        end else begin
          if (ap[3]) n.lap = !m.lap;
          if (m.state == S_PAUSE && ap[0] && !ap[1]) n.state = S_RUN;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, reset, req, 1'b1);
    m0 <= step(m0, reset, req, 1'b0);
  end

  task automatic pulse_req(logic [3:0] m);
    req = m;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'b0001;
    repeat (3) @(negedge clk);
    tests_run++;
    if (v1 !== RV || v0 !== RV) begin tests_failed++; $display("FAIL reset_values: got %h/%h expected %h", v1, v0, RV); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (run1 !== 1'b0 || v1 !== exp_vec(m1)) begin tests_failed++; $display("FAIL held_start_no_pulse: got %h expected %h", v1, exp_vec(m1)); end
    req = 4'b0000;
    repeat (4) @(negedge clk);
    tests_run++;
    if (run1 !== 1'b0 || run0 !== 1'b0) begin tests_failed++; $display("FAIL release_idle: running got %b/%b expected 0", run1, run0); end
  endtask

  task automatic test_start_tick;
    req = 4'b0001;
    @(negedge clk); req = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (run1 !== 1'b0) begin tests_failed++; $display("FAIL start_latency_early: running got %b expected 0", run1); end
    @(negedge clk);
    tests_run++;
    if (run1 !== 1'b1 || cnt1 !== 8'h00) begin tests_failed++; $display("FAIL start_latency: running/count got %b/%h expected 1/00", run1, cnt1); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h00) begin tests_failed++; $display("FAIL pre_tick: count got %h expected 00", cnt1); end
    @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h01 || cnt0 !== 8'h01) begin tests_failed++; $display("FAIL first_tick: count got %h/%h expected 01", cnt1, cnt0); end
    repeat (36) @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h10 || v1 !== exp_vec(m1) || v0 !== exp_vec(m0)) begin
      tests_failed++; $display("FAIL ten_ticks: got %h/%h expected %h (count 10)", v1, v0, exp_vec(m1));
    end
  endtask

  task automatic test_pause;
    pulse_req(4'b0010);
    pulse_req(4'b0100);
    tests_run++;
    if ({run1, ovf1, cnt1} !== 10'h000) begin tests_failed++; $display("FAIL clear_from_pause: got %h expected 000", {run1, ovf1, cnt1}); end
    pulse_req(4'b0001);
    repeat (19) @(negedge clk);
    pulse_req(4'b0010);
    tests_run++;
    if (cnt1 !== 8'h05 || run1 !== 1'b0) begin tests_failed++; $display("FAIL pause_at_05: count/running got %h/%b expected 05/0", cnt1, run1); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h05 || v1 !== exp_vec(m1)) begin tests_failed++; $display("FAIL pause_hold: got %h expected %h", v1, exp_vec(m1)); end
    pulse_req(4'b0001);
    @(negedge clk);
    tests_run++;
    if (run1 !== 1'b1 || cnt1 !== 8'h05) begin tests_failed++; $display("FAIL resume_phase_a: got %b/%h expected 1/05", run1, cnt1); end
    @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h06) begin tests_failed++; $display("FAIL resume_phase_b: count got %h expected 06", cnt1); end
  endtask

  task automatic test_wrap;
    for (int c = 0; c < 600 && m1.cnt != MAXC; c++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_vec(m1) || v0 !== exp_vec(m0)) begin
        tests_failed++; $display("FAIL run_to_99: got %h/%h expected %h/%h", v1, v0, exp_vec(m1), exp_vec(m0));
      end
    end
    for (int c = 0; c < 10 && m1.cnt == MAXC; c++) @(negedge clk);
    tests_run++;
    if (m1.cnt != 0) begin tests_failed++; $display("FAIL wrap_timeout: model count %0d expected 0", m1.cnt); end
    tests_run++;
    if ({run1, ovf1, cnt1} !== {1'b1, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL wrap: got %h expected 300", {run1, ovf1, cnt1}); end
    tests_run++;
    if ({run0, ovf0, cnt0} !== {1'b0, 1'b1, 8'h99}) begin tests_failed++; $display("FAIL saturate: got %h expected 199", {run0, ovf0, cnt0}); end
    repeat (6) @(negedge clk);
    tests_run++;
    if (cnt0 !== 8'h99 || run0 !== 1'b0) begin tests_failed++; $display("FAIL ovf_hold: got %h/%b expected 99/0", cnt0, run0); end
    pulse_req(4'b0100);
    tests_run++;
    if ({run0, ovf0, cnt0} !== 10'h000) begin tests_failed++; $display("FAIL ovf_clear: got %h expected 000", {run0, ovf0, cnt0}); end
    tests_run++;
    if (run1 !== 1'b1 || ovf1 !== 1'b1) begin tests_failed++; $display("FAIL clear_in_run: got %b%b expected 11", run1, ovf1); end
  endtask

  task automatic test_lap;
    for (int c = 0; c < 600 && !(m1.cnt == 12 && m1.presc == 0); c++) @(negedge clk);
    pulse_req(4'b1000);
    tests_run++;
    if (cnt1 !== 8'h12) begin tests_failed++; $display("FAIL lap_at_12: count got %h expected 12", cnt1); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (!((an1 == 2'b10 && seg1 == 7'h24) || (an1 == 2'b01 && seg1 == 7'h79))) begin
        tests_failed++; $display("FAIL lap_frozen: an/segment got %b/%h expected digit of 12", an1, seg1);
      end
      tests_run++;
      if (seg0 !== 7'h40 || run0 !== 1'b0) begin tests_failed++; $display("FAIL lap_in_idle: got %h/%b expected 40/0", seg0, run0); end
    end
    tests_run++;
    if (cnt1 !== 8'h14) begin tests_failed++; $display("FAIL lap_count_runs: count got %h expected 14", cnt1); end
    pulse_req(4'b1000);
    pulse_req(4'b0001);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_vec(m1) || v0 !== exp_vec(m0)) begin
        tests_failed++; $display("FAIL lap_release_track: got %h/%h expected %h/%h", v1, v0, exp_vec(m1), exp_vec(m0));
      end
    end
  endtask

  task automatic test_conflict;
    pulse_req(4'b0011);
    tests_run++;
    if (run1 !== 1'b0 || run0 !== 1'b0 || v1 !== exp_vec(m1)) begin tests_failed++; $display("FAIL start_stop_run: running got %b/%b expected 0/0", run1, run0); end
    pulse_req(4'b1000);
    pulse_req(4'b1100);
    tests_run++;
    if ({run1, ovf1, cnt1} !== 10'h000 || {run0, ovf0, cnt0} !== 10'h000) begin
      tests_failed++; $display("FAIL clear_lap: got %h/%h expected 000", {run1, ovf1, cnt1}, {run0, ovf0, cnt0});
    end
    pulse_req(4'b0011);
    tests_run++;
    if (run1 !== 1'b0) begin tests_failed++; $display("FAIL start_stop_idle: running got %b expected 0", run1); end
    pulse_req(4'b0001);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests_run++;
      if (v1 !== exp_vec(m1) || v0 !== exp_vec(m0)) begin
        tests_failed++; $display("FAIL lap_cleared_track: got %h/%h expected %h/%h", v1, v0, exp_vec(m1), exp_vec(m0));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] ea;
    for (int c = 0; c < 400 && m1.cnt != 47; c++) @(negedge clk);
    tests_run++;
    if (cnt1 !== 8'h47) begin tests_failed++; $display("FAIL reach_47: count got %h expected 47", cnt1); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (v1 !== RV || v0 !== RV) begin tests_failed++; $display("FAIL reset_mid_run: got %h/%h expected %h", v1, v0, RV); end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ea = (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
      tests_run++;
      if ({an1, dp1, an0, dp0} !== {ea, 1'b1, ea, 1'b1} || cnt1 !== 8'h00) begin
        tests_failed++; $display("FAIL scan_seq: an/dp got %b/%b expected %b/1 at cycle %0d", an1, dp1, ea, k);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] m;
    int gap;
    for (int it = 0; it < 40; it++) begin
      m = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) m = m | 4'($urandom_range(0, 15));
      req = m;
      @(negedge clk);
      req = 4'b0000;
      gap = $urandom_range(2, 25);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        tests_run++;
        if (v1 !== exp_vec(m1) || v0 !== exp_vec(m0)) begin
          tests_failed++; $display("FAIL random_seq: got %h/%h expected %h/%h", v1, v0, exp_vec(m1), exp_vec(m0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_pause();
    test_wrap();
    test_lap();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
